// File: rtl/cic_interpolator.sv
// CIC interpolator: low-rate comb chain, zero-stuffing upsampler, full-rate integrator chain and a
// shift/saturate output stage. d_clk requests one upstream sample every R_eff clocks.
module cic_interpolator #(
  parameter int unsigned width  = 18,
  parameter int unsigned stages = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        interpolation_ratio,
  input  logic [4:0]         gain_shift,
  input  logic signed [7:0]  d_in,
  output logic signed [7:0]  d_out,
  output logic               d_clk
);

  localparam logic signed [width-1:0] SatMax = {{(width-7){1'b0}}, 7'h7f};
  localparam logic signed [width-1:0] SatMin = {{(width-7){1'b1}}, 7'h00};

  logic [15:0]             cnt_q;
  logic [15:0]             r_eff_q;
  logic [15:0]             r_port;
  logic                    d_clk_q;

  logic signed [width-1:0] d_ext;
  logic signed [width-1:0] comb_x [stages];
  logic signed [width-1:0] comb_dly_q [stages];
  logic signed [width-1:0] comb_last;
  logic signed [width-1:0] comb_out_q;
  logic                    comb_vld_q;

  logic signed [width-1:0] up;
  logic signed [width-1:0] integ_q [stages];
  logic signed [width-1:0] shifted;
  logic signed [7:0]       d_out_d;
  logic signed [7:0]       d_out_q;

  // A programmed ratio of 0 behaves as 1.
  assign r_port = (interpolation_ratio == 16'd0) ? 16'd1 : interpolation_ratio;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      d_clk_q <= 1'b0;
      r_eff_q <= r_port;
    end else if (cnt_q == r_eff_q - 16'd1) begin
      cnt_q   <= '0;
      d_clk_q <= 1'b1;
      r_eff_q <= r_port;
    end else begin
      cnt_q   <= cnt_q + 16'd1;
      d_clk_q <= 1'b0;
    end
  end

  assign d_ext = {{(width-8){d_in[7]}}, d_in};

  // Comb chain is combinational from d_in; comb_x[k] is the input seen by stage k.
  always_comb begin
    logic signed [width-1:0] acc;
    acc = d_ext;
    for (int unsigned k = 0; k < stages; k++) begin
      comb_x[k] = acc;
      acc       = acc - comb_dly_q[k];
    end
    comb_last = acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < stages; k++) begin
        comb_dly_q[k] <= '0;
      end
      comb_out_q <= '0;
      comb_vld_q <= 1'b0;
    end else begin
      comb_vld_q <= d_clk_q;
      if (d_clk_q) begin
        for (int unsigned k = 0; k < stages; k++) begin
          comb_dly_q[k] <= comb_x[k];
        end
        comb_out_q <= comb_last;
      end
    end
  end

  assign up = comb_vld_q ? comb_out_q : '0;

  // Integrators wrap freely; the comb differences cancel the growth modulo 2^width.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < stages; k++) begin
        integ_q[k] <= '0;
      end
    end else begin
      integ_q[0] <= integ_q[0] + up;
      for (int unsigned k = 1; k < stages; k++) begin
        integ_q[k] <= integ_q[k] + integ_q[k-1];
      end
    end
  end

  assign shifted = integ_q[stages-1] >>> gain_shift;

  always_comb begin
    d_out_d = shifted[7:0];
    if (shifted > SatMax) begin
      d_out_d = 8'sd127;
    end else if (shifted < SatMin) begin
      d_out_d = -8'sd128;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out_q <= '0;
    end else begin
      d_out_q <= d_out_d;
    end
  end

  assign d_out = d_out_q;
  assign d_clk = d_clk_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Bench for cic_interpolator: directed strobe/impulse/DC/saturation steps plus random traffic,
// every cycle compared with an arithmetic model (Nth differences and binomial integration sums).
module tb_cic_interpolator;

  localparam int W = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       ratio;
  logic [4:0]        gs;
  logic signed [7:0] d_in;
  logic signed [7:0] d_out;
  logic              d_clk;

  cic_interpolator #(
    .width (W),
    .stages(3)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .interpolation_ratio(ratio),
    .gain_shift         (gs),
    .d_in               (d_in),
    .d_out              (d_out),
    .d_clk              (d_clk)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint e = 0;
  longint next_strobe = 0;
  bit     dclk_exp = 1'b0;
  longint dout_exp = 0;
  longint xh [3];
  longint c_q [$];
  longint a_q [$];
  int     ramp = 0;
  int     imp [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

  function automatic longint eff(logic [15:0] r);
    return (r == 16'd0) ? 64'sd1 : longint'(r);
  endfunction

  function automatic longint out_of(longint i3, logic [4:0] s);
    longint v;
    v = i3 & ((64'sd1 <<< W) - 1);
    if (v >= (64'sd1 <<< (W - 1))) v = v - (64'sd1 <<< W);
    v = v >>> s;
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return v;
  endfunction

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: update the model with the inputs present at the edge, then check both outputs.
  task automatic step();
    logic              rst_s;
    logic [15:0]       ratio_s;
    logic [4:0]        gs_s;
    logic signed [7:0] d_s;
    longint            i3;
    longint            j;
    longint            c;
    rst_s   = rst;
    ratio_s = ratio;
    gs_s    = gs;
    d_s     = d_in;
    @(posedge clk);
    e++;
    if (rst_s) begin
      c_q.delete();
      a_q.delete();
      for (int k = 0; k < 3; k++) xh[k] = 0;
      next_strobe = e + eff(ratio_s);
      dclk_exp    = 1'b0;
      dout_exp    = 0;
    end else begin
      i3 = 0;
      for (int m = 0; m < c_q.size(); m++) begin
        j = e - 2 - a_q[m];
        if (j >= 2) i3 += c_q[m] * ((j * (j - 1)) / 2);
      end
      dout_exp = out_of(i3, gs_s);
      if (dclk_exp) begin
        c = longint'(d_s) - 3 * xh[0] + 3 * xh[1] - xh[2];
        xh[2] = xh[1];
        xh[1] = xh[0];
        xh[0] = longint'(d_s);
        c_q.push_back(c);
        a_q.push_back(e);
      end
      if (e == next_strobe) begin
        dclk_exp    = 1'b1;
        next_strobe = e + eff(ratio_s);
      end else begin
        dclk_exp = 1'b0;
      end
    end
    #1;
    chk("model_dout", $signed(d_out), dout_exp);
    chk("model_dclk", d_clk, dclk_exp);
  endtask

  // mode 0: zeros, 1: constant cval, 2: random, 3: ramp
  task automatic run(int n, int mode, int cval);
    for (int i = 0; i < n; i++) begin
      if (dclk_exp) begin
        case (mode)
          0: d_in = 8'sd0;
          1: d_in = cval[7:0];
          2: d_in = 8'($urandom);
          default: begin
            d_in = ramp[7:0];
            ramp += 3;
          end
        endcase
      end
      step();
    end
  endtask

  task automatic impulse(string tag);
    int guard;
    guard = 0;
    gs    = 5'd0;
    ratio = 16'd4;
    d_in  = 8'sd0;
    while (!dclk_exp && guard < 20) begin
      step();
      guard++;
    end
    chk({tag, "_strobe"}, d_clk, 1);
    d_in = 8'sd1;
    step();
    d_in = 8'sd0;
    repeat (3) step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk(tag, $signed(d_out), imp[i]);
    end
    step();
    chk({tag, "_tail"}, $signed(d_out), 0);
  endtask

  initial begin
    rst   = 1'b1;
    ratio = 16'd4;
    gs    = 5'd0;
    d_in  = 8'sd0;
    repeat (3) step();
    chk("reset_dout", $signed(d_out), 0);
    chk("reset_dclk", d_clk, 0);

    // First request R_eff edges after release, then every R_eff clocks.
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("first_strobe_low", d_clk, 0);
    end
    step();
    chk("first_strobe", d_clk, 1);
    repeat (3) begin
      step();
      chk("period4_low", d_clk, 0);
    end
    step();
    chk("period4_high", d_clk, 1);

    // Ratio change mid-period: current period still ends at 4.
    repeat (2) step();
    ratio = 16'd8;
    step();
    chk("ratio_change_low", d_clk, 0);
    step();
    chk("ratio_change_old_period", d_clk, 1);
    repeat (7) begin
      step();
      chk("period8_low", d_clk, 0);
    end
    step();
    chk("period8_high", d_clk, 1);

    ratio = 16'd4;
    rst   = 1'b1;
    step();
    rst = 1'b0;
    impulse("impulse");

    run(80, 1, 5);
    chk("dc_gain", $signed(d_out), 80);
    gs = 5'd4;
    step();
    chk("dc_shift4", $signed(d_out), 5);

    gs = 5'd0;
    run(80, 1, 127);
    chk("sat_pos", $signed(d_out), 127);
    run(80, 1, -128);
    chk("sat_neg", $signed(d_out), -128);

    ratio = 16'd0;
    run(10, 0, 0);
    repeat (5) begin
      step();
      chk("ratio0_dclk", d_clk, 1);
    end
    ratio = 16'd1;
    repeat (5) begin
      step();
      chk("ratio1_dclk", d_clk, 1);
    end

    ratio = 16'd4;
    run(40, 3, 0);
    rst = 1'b1;
    step();
    chk("midreset_dout", $signed(d_out), 0);
    chk("midreset_dclk", d_clk, 0);
    rst = 1'b0;
    impulse("impulse_after_reset");

    for (int s = 0; s < 30; s++) begin
      ratio = 16'($urandom_range(0, 8));
      gs    = 5'($urandom_range(0, 20));
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      run($urandom_range(5, 80), 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cic_interpolator.md
# cic_interpolator

Multi-stage CIC interpolator: the transmit-side counterpart of `cic_decimator` in the DSP chain. It pulls 8-bit signed samples at the low rate and produces an 8-bit signed stream at the full `clk` rate, upsampled by a run-time ratio R. The datapath is N comb stages at the low rate, a zero-stuffing upsampler, N integrator stages at the high rate, and a shift/saturate output stage. `d_clk` is a sample-request strobe that paces the upstream source.

## Interface
- `width`, 18: internal two's-complement datapath width for comb and integrator registers.
- `stages`, 3: number of comb stages and number of integrator stages (N).
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `interpolation_ratio` in 16: R, latched at wrap; 0 is treated as 1.
- `gain_shift` in 5: arithmetic right shift applied before saturation; values ≥ `width` give 0 or -1.
- `d_in` in 8 signed: low-rate input sample; sampled on the edge where `d_clk`=1.
- `d_out` out 8 signed: high-rate output, registered.
- `d_clk` out 1: one-cycle request/accept strobe, once per R clocks.

## Operation
- Ratio counter `cnt`, with R_eff latched from `interpolation_ratio` (0→1).
  - On `rst`: `cnt`<=0, `d_clk`<=0, R_eff<=port value.
  - Otherwise, if `cnt`==R_eff-1: `cnt`<=0, `d_clk`<=1, R_eff reloads.
  - Otherwise: `cnt`<=`cnt`+1, `d_clk`<=0.
- Ratio changes mid-period take effect only at wrap; there are no glitch pulses.
- R_eff=1: `d_clk` is high on every cycle after the first edge out of reset.
- Accept edge: an edge at which `d_clk`=1.
  - `d_in` is sign-extended to `width`.
  - It passes combinationally through the comb chain: y_i = x_i − x_i_prev.
  - Each x_i_prev updates only on accept edges.
  - The last comb output is registered into `comb_out` and a one-cycle `comb_vld` is set.
- Upsampler: u = `comb_out` when `comb_vld`, else 0.
- Integrators, registered chain updating every cycle: I1<=I1+u, Ik<=Ik+I(k-1).
- All comb/integrator arithmetic wraps modulo 2^`width`. No saturation inside the chain; wrap is correct by the CIC property.
- Width requirement: `width` ≥ 8 + `stages`·ceil(log2 R). The default supports R≤8 at N=3; larger R is an integration error, not detected.
- Output: `d_out`<=sat8(I_N >>> `gain_shift`), clamped to [−128, 127].
- DC gain before shift is R^(N−1).
- Reset values: `d_out`=0, `d_clk`=0, `cnt`=0, all comb delays, `comb_out`, `comb_vld` and integrators = 0.
- Reset mid-operation: all state clears on that edge, and the in-flight sample is discarded.
  - Request pacing restarts from `cnt`=0.
  - The first `d_clk` after release occurs R_eff edges later (1 edge for R_eff=1).

## Timing
- Accept at edge k, then:
  - `comb_out` valid after edge k.
  - I1 updated at edge k+1.
  - I_N updated at edge k+N.
  - `d_out` reflects the sample at edge k+N+1 (N=3: 4 edges).
- `d_clk` period is exactly R_eff clocks at a steady ratio; duty is 1 cycle high (R_eff≥2).
- Upstream must present `d_in` stable at the accept edge. There is no backpressure; the source must not stall.
- `gain_shift` is applied combinationally to the final register input and takes effect on the next edge.

## Test plan
- **Impulse:** N=3, R=4, `gain_shift`=0.
  - Stimulus: one accepted 1, then zeros.
  - Required: `d_out` = 1,3,6,10,12,12,10,6,3,1 on consecutive cycles, first value 4 edges after accept, then 0.
- **DC:** R=4, constant `d_in`=5.
  - `gain_shift`=0: steady `d_out`=80.
  - `gain_shift`=4: steady `d_out`=5.
- **Saturation:** R=4, `gain_shift`=0.
  - `d_in`=127 steady → `d_out`=127.
  - `d_in`=−128 steady → `d_out`=−128; no wrap artifacts.
- **Strobe and ratio:**
  - After reset with R=4: first `d_clk` 4 edges after release, then every 4 clocks.
  - Change to 8 mid-period: the current period completes at 4, subsequent periods are 8.
  - R=0 and R=1: `d_clk` stays high continuously.
- **Reset mid-stream:** assert `rst` during a ramp.
  - `d_out`=0 and `d_clk`=0 the edge after assertion.
  - After release, the impulse test reproduces the exact sequence.
- **File regression:** read `x.txt` and write `x_out.txt`.
  - Cascade `cic_interpolator`→`cic_decimator` with R=4, N=3 and the gain compensated.
  - Required: output matches the delayed input within ±1 LSB.
